vga_frame_reader: RTL and testbench

- Read-side scanner for the 640x480 framebuffer RAM (DEPTH 307200). The processor writes pixels into the framebuffer; this block reads them out.
- Generates VGA timing and issues sequential read addresses to the RAM's port (negedge-sampled, registered dataOut).
- Delivers pixel data aligned with hSync/vSync/active to the DAC/pin driver.

---
 rtl/vga_frame_reader.sv | 146 ++++++++++++++
 tb/tb_vga_frame_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Read-side VGA scanner: generates raster timing and streams framebuffer words to the pin driver.
// Define VGA_PIXEL_DOUBLE_EN to scan a quarter-size buffer with every word repeated 2x2.
module vga_frame_reader #(
  parameter int DATA_WIDTH    = 12,
  parameter int ADDRESS_WIDTH = 19,
  parameter int CLK_DIV       = 4,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut,
  output logic [DATA_WIDTH-1:0]    pixel,
  output logic                     hSync,
  output logic                     vSync,
  output logic                     active,
  output logic                     frame_start,
  output logic                     scanning
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div;
  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic tick, frame_begin, frame_end, h_last, h_end, last_line;
  logic visible, hsync_raw, vsync_raw, scan_tick;

  always_comb begin
    tick        = (int'(div) == CLK_DIV - 1);
    h_last      = (int'(h) == H_TOTAL - 1);
    h_end       = (int'(h) == H_ACTIVE - 1);
    last_line   = (int'(v) == V_ACTIVE - 1);
    frame_begin = (h == '0) && (v == '0);
    frame_end   = h_last && (int'(v) == V_TOTAL - 1);
    visible     = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    hsync_raw   = !((int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC));
    vsync_raw   = !((int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (h_last) begin
          h <= '0;
          v <= (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: the next state gets a default first so no latch is inferred on unlisted paths.
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        IDLE:    if (frame_begin && enable) state_next = SCAN;
        SCAN:    if (frame_end && !enable)  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Gate on the next state so the first pixel of a newly enabled frame is fetched too.
  assign scan_tick = tick && visible && (state_next == SCAN);

`ifdef VGA_PIXEL_DOUBLE_EN
  logic [ADDRESS_WIDTH-1:0] line_base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      line_base <= '0;
    end else if (tick && frame_end) begin
      ram_addr  <= '0;
      line_base <= '0;
    end else begin
      if (scan_tick && (h == '0) && !v[0]) line_base <= ram_addr;
      // Odd lines re-read the row fetched by the even line just above them.
      if (tick && (state_next == SCAN) && h_last && !v[0] && (int'(v) < V_ACTIVE - 1))
        ram_addr <= line_base;
      else if (scan_tick && h[0] && !(h_end && (!v[0] || last_line)))
        ram_addr <= ram_addr + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= '0;
    end else if (tick && frame_end) begin
      ram_addr <= '0;
    end else if (scan_tick && !(h_end && last_line)) begin
      ram_addr <= ram_addr + 1'b1;
    end
  end
`endif

  // Data returns one tick after its address, so the timing strobes are delayed to match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel  <= '0;
      active <= 1'b0;
      hSync  <= 1'b1;
      vSync  <= 1'b1;
    end else if (tick) begin
      pixel  <= scan_tick ? ram_dataOut : '0;
      active <= visible;
      hSync  <= hsync_raw;
      vSync  <= vsync_raw;
    end
  end

  assign frame_start = tick && frame_begin;
  assign scanning    = (state == SCAN);
  assign ram_wEn     = 1'b0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a shrunken raster (16x10 ticks, 8x6 visible).
// Build with VGA_PIXEL_DOUBLE_EN defined to check the 2x2 pixel-doubling address pattern.
module tb_vga_frame_reader;

  localparam int DW       = 12;
  localparam int AW       = 19;
  localparam int CLK_DIV  = 4;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = 16;
  localparam int V_TOTAL  = 10;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
`ifdef VGA_PIXEL_DOUBLE_EN
  localparam int LAST_ADDR = 11;
`else
  localparam int LAST_ADDR = 47;
`endif

  typedef struct {
    int addr;
    int pix;
  } item_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataOut = '0;
  logic [DW-1:0] pixel;
  logic          hsync, vsync, active, frame_start, scanning;

  int checks = 0;
  int failures = 0;
  int cyc;
  int fs_seen = 0;
  int fs_expected = 0;

  item_t addr_q[$];
  bit    frame_q[$];

  vga_frame_reader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CLK_DIV(CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataOut(ram_dataOut),
    .pixel(pixel), .hSync(hsync), .vSync(vsync), .active(active),
    .frame_start(frame_start), .scanning(scanning)
  );

  always #5 clk = ~clk;

  // Framebuffer model: word at each address is the address itself, registered on negedge.
  always @(negedge clk) ram_dataOut <= ram_addr[11:0];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_addr(input int h, input int v);
`ifdef VGA_PIXEL_DOUBLE_EN
    return (v / 2) * (H_ACTIVE / 2) + h / 2;
`else
    return v * H_ACTIVE + h;
`endif
  endfunction

  task automatic push_frame(input bit scan);
    item_t it;
    frame_q.push_back(scan);
    for (int v = 0; v < V_ACTIVE; v++) begin
      for (int h = 0; h < H_ACTIVE; h++) begin
        it.addr = scan ? exp_addr(h, v) : 0;
        it.pix  = it.addr & 32'hfff;
        addr_q.push_back(it);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pixel"}, pixel, 0);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_active"}, active, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_scanning"}, scanning, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wen"}, ram_wEn, 0);
  endtask

  task automatic wait_period(input int p);
    int guard = 0;
    while (!(reset_n && cyc == p * CLK_DIV + CLK_DIV - 1)) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        $display("FAIL wait_period: period %0d never reached", p);
        $fatal(1, "bench timeout");
      end
    end
  endtask

  // Monitor: samples on the last negedge of every pixel period.
  item_t pend;
  bit    cur_scan = 1'b0;
  bit    prev_scan = 1'b0;
  always @(negedge clk) begin : monitor
    int p, h, v, ph, pv;
    bit exp_act, exp_hs, exp_vs;
    int exp_pix;
    if (reset_n && frame_start) fs_seen++;
    if (reset_n && (cyc % CLK_DIV) == CLK_DIV - 1) begin
      p = cyc / CLK_DIV;
      h = p % H_TOTAL;
      v = (p / H_TOTAL) % V_TOTAL;
      if (h == 0 && v == 0) begin
        prev_scan = (p == 0) ? 1'b0 : cur_scan;
        fs_expected++;
        if (frame_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_queue: empty at period %0d, required an entry", p);
          cur_scan = 1'b0;
        end else begin
          cur_scan = frame_q.pop_front();
        end
      end
      check("scanning", scanning, (h == 0 && v == 0) ? (prev_scan && cur_scan) : cur_scan);
      check("frame_start", frame_start, (h == 0 && v == 0));

      if (p == 0) begin
        exp_act = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_pix = 0;
      end else begin
        ph      = (p - 1) % H_TOTAL;
        pv      = ((p - 1) / H_TOTAL) % V_TOTAL;
        exp_act = (ph < H_ACTIVE) && (pv < V_ACTIVE);
        exp_hs  = !((ph >= H_ACTIVE + H_FP) && (ph < H_ACTIVE + H_FP + H_SYNC));
        exp_vs  = !((pv >= V_ACTIVE + V_FP) && (pv < V_ACTIVE + V_FP + V_SYNC));
        exp_pix = exp_act ? pend.pix : 0;
      end
      check("active", active, exp_act);
      check("hsync", hsync, exp_hs);
      check("vsync", vsync, exp_vs);
      check("pixel", pixel, exp_pix);

      if (h < H_ACTIVE && v < V_ACTIVE) begin
        if (addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL addr_queue: empty at period %0d, required an entry", p);
          pend.addr = 0;
          pend.pix  = 0;
        end else begin
          pend = addr_q.pop_front();
          check("ram_addr", ram_addr, pend.addr);
        end
      end
      if (h == H_TOTAL - 1 && v == V_TOTAL - 1)
        check("last_addr", ram_addr, cur_scan ? LAST_ADDR : 0);
    end
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values("por");
    // Frames 0..5: idle, scan, scan (enable drops mid-frame), idle, scan, scan (cut by reset).
    push_frame(0); push_frame(1); push_frame(1);
    push_frame(0); push_frame(1); push_frame(1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    wait_period(7 * H_TOTAL);
    enable = 1'b1;
    wait_period(2 * FRAME + 3 * H_TOTAL);
    enable = 1'b0;
    wait_period(3 * FRAME + 4 * H_TOTAL);
    enable = 1'b1;

    wait_period(5 * FRAME + 2 * H_TOTAL + 5);
    check("pre_reset_scanning", scanning, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async");
    frame_q.delete();
    addr_q.delete();
    push_frame(1);
    push_frame(1);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    wait_period(FRAME + 2);
    check("frame_start_count", fs_seen, fs_expected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
